// File: rtl/t_counter_pkg.sv
// Shared definitions for the t_counter family: mode encodings.
package t_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD   = 2'b00;
  localparam mode_t MODE_TOGGLE = 2'b01;
  localparam mode_t MODE_UP     = 2'b10;
  localparam mode_t MODE_DOWN   = 2'b11;

endpackage

// File: rtl/t_counter.sv
// WIDTH-bit counter/toggle register with hold, per-bit toggle, modulo up and
// modulo down counting, synchronous clear/load and a registered wrap flag.
module t_counter
  import t_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  // Top of the count range, truncated to WIDTH bits so MODULUS=2**WIDTH
  // yields all-ones and wraps coincide with natural overflow.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_modulus_check
    $error("t_counter: MODULUS %0d outside legal range 2..2**WIDTH", MODULUS);
  end

  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic [WIDTH-1:0] q_tog;

  assign q_tog = q ^ t;

  // Next-state selection: clr over load over enabled mode operation.
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = d;
    end else if (en) begin
      case (mode)
        MODE_HOLD: q_next = q;
        MODE_TOGGLE: begin
          q_next  = q_tog;
          tc_next = &q_tog;
        end
        MODE_UP: begin
          if (q >= MAX_VAL) begin
            q_next  = '0;
            tc_next = 1'b1;
          end else begin
            q_next = q + ONE;
          end
        end
        MODE_DOWN: begin
          if (q == '0) begin
            q_next  = MAX_VAL;
            tc_next = 1'b1;
          end else if (q > MAX_VAL) begin
            // Out-of-range value from a raw load or toggle: snap to the top
            // without flagging a wrap.
            q_next = MAX_VAL;
          end else begin
            q_next = q - ONE;
          end
        end
        default: q_next = q;
      endcase
    end
  end

  // State register; reset clears value and flag without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      q  <= q_next;
      tc <= tc_next;
    end
  end

endmodule
